mul_div_unit: RTL

- Iterative multiply/divide execution unit that produces the HI/LO write-back stream consumed by the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU on operands captured at start.
- Presents a one-cycle write strobe with the 64-bit result; {hi, lo} maps directly onto the HI/LO write port.
- Sits in EX stage; the pipeline stalls on `busy`, and an exception or branch flush aborts the operation via `cancel`.

---
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between EX stage and the multiply/divide unit
// Ports (signals):
//   start, op[1:0], src_a, src_b, cancel  : request side, driven by the pipeline
//   busy, done, we_o[1:0], hi_o, lo_o     : status and HI/LO write-back, driven by the unit
// Modports: master = pipeline side, slave = mul_div_unit side.
interface mul_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              cancel;
    logic              busy;
    logic              done;
    logic [1:0]        we_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, we_o, hi_o, lo_o
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, we_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write port
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mul_div_unit_if.slave (start/op/src_a/src_b/cancel in; busy/done/we_o/hi_o/lo_o out)
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_sgn;      // signed operation (MULT/DIV)
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;      // partial remainder
    logic [DATA_W-1:0] r_quo;      // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [DATA_W-1:0] r_dvs;      // |divisor|
    logic              r_neg_q;
    logic              r_neg_r;
    logic [DATA_W-1:0] r_res_hi;   // result staged for the DONE cycle
    logic [DATA_W-1:0] r_res_lo;
    logic [DATA_W-1:0] r_out_hi;   // last committed result, held between completions
    logic [DATA_W-1:0] r_out_lo;

    logic                w_accept;
    logic                w_in_sgn;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [2*DATA_W-1:0] w_ma;
    logic [2*DATA_W-1:0] w_mb;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_diff;
    logic                w_last;
    logic                w_fire;

    assign w_accept = bus.start && !bus.cancel;
    assign w_in_sgn = ~bus.op[0];
    assign w_abs_a  = (w_in_sgn && bus.src_a[DATA_W-1]) ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_abs_b  = (w_in_sgn && bus.src_b[DATA_W-1]) ? (~bus.src_b + 1'b1) : bus.src_b;

    // Sign-extending to full width lets one unsigned multiplier serve both
    // MULT and MULTU; the low 2*DATA_W bits are the correct two's-complement product.
    assign w_ma   = {{DATA_W{r_sgn & r_a[DATA_W-1]}}, r_a};
    assign w_mb   = {{DATA_W{r_sgn & r_b[DATA_W-1]}}, r_b};
    assign w_prod = w_ma * w_mb;

    // One restoring-division step; the extra top bit of w_diff is the borrow.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

    // A cancel landing in the DONE cycle kills the write and keeps the old result visible.
    assign w_fire   = (r_state == S_DONE) && !bus.cancel;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = w_fire;
    assign bus.we_o = {2{w_fire}};
    assign bus.hi_o = w_fire ? r_res_hi : r_out_hi;
    assign bus.lo_o = w_fire ? r_res_lo : r_out_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!bus.op[1]) begin
                        w_next = S_MUL;
                    end else if (bus.src_b == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL:   w_next = S_DONE;
            S_DIV:   w_next = w_last ? S_FIX : S_DIV;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.cancel && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sgn    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_out_hi <= '0;
            r_out_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sgn   <= w_in_sgn;
                        r_a     <= bus.src_a;
                        r_b     <= bus.src_b;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_neg_q <= w_in_sgn && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                        r_neg_r <= w_in_sgn && bus.src_a[DATA_W-1];
                        if (bus.op[1] && (bus.src_b == '0)) begin
                            r_res_hi <= bus.src_a;
                            r_res_lo <= '1;
                        end
                    end
                end
                S_MUL: begin
                    r_res_hi <= w_prod[2*DATA_W-1:DATA_W];
                    r_res_lo <= w_prod[DATA_W-1:0];
                end
                S_DIV: begin
                    if (!w_diff[DATA_W]) begin
                        r_rem <= w_diff[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_res_lo <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                    r_res_hi <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                end
                S_DONE: begin
                    if (!bus.cancel) begin
                        r_out_hi <= r_res_hi;
                        r_out_lo <= r_res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
